micromips_mem_ir_unit: RTL
==========================

MICROMIPS_MEM_IR_UNIT -- requirements
Module: micromips_mem_ir_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port MemRead  input  1  read command from control FSM, sampled in IDLE.
REQ-004 SHALL have port MemWrite  input  1  write command from control FSM, sampled in IDLE.
REQ-005 SHALL have port irwrite  input  1  read result targets IR, not MDR.
REQ-006 SHALL have port instdata  input  1  address select: 0 = pc, 1 = alu_addr.
REQ-007 SHALL have port pc  input  32  instruction address.
REQ-008 SHALL have port alu_addr  input  32  data address from ALU output register.
REQ-009 SHALL have port wdata  input  32  store data (rt).
REQ-010 SHALL have port mem_req  output  1  bus request, registered.
REQ-011 SHALL have port mem_we  output  1  bus write enable, valid with mem_req.
REQ-012 SHALL have port mem_addr  output  32  bus word address, held stable while mem_req=1.
REQ-013 SHALL have port mem_wdata  output  32  bus write data, held stable while mem_req=1.
REQ-014 SHALL have port mem_rdata  input  32  bus read data, valid when mem_ack=1.
REQ-015 SHALL have port mem_ack  input  1  single-cycle bus completion.
REQ-016 SHALL have port ir  output  32  instruction register.
REQ-017 SHALL have port opcode  output  6  ir[31:26], to control FSM.
REQ-018 SHALL have port funct  output  6  ir[5:0], to control FSM.
REQ-019 SHALL have port mdr  output  32  memory data register.
REQ-020 SHALL have port mem_busy  output  1  stall to control FSM; high whenever state is REQ.
REQ-021 SHALL have port addr_err  output  1  one-cycle pulse: misaligned access rejected.
REQ-022 SHALL have port timeout_err  output  1  one-cycle pulse: access aborted, no ack.

Function
REQ-023 SHALL implement states IDLE and REQ.
REQ-024 IDLE, MemRead|MemWrite=1 at edge: latch address (instdata ? alu_addr : pc), wdata, we=MemWrite, dest=(irwrite & ~instdata); go to REQ; mem_req=1 from that edge.
REQ-025 MemRead and MemWrite both 1 SHALL be treated as a write.
REQ-026 Latched address with addr[1:0]!=0 SHALL NOT enter REQ; addr_err=1 for the next cycle only; IR/MDR unchanged.
REQ-027 REQ, mem_ack=1 at edge: mem_req=0, state=IDLE; on read, mem_rdata loads IR if dest=1, else MDR; on write, IR/MDR unchanged.
REQ-028 Minimum access = 2 cycles (request edge, ack edge); no back-to-back request is accepted in the ack cycle.
REQ-029 5-bit wait counter SHALL clear on REQ entry and increment each REQ cycle without ack; at count 16 with no ack, abort to IDLE, mem_req=0, timeout_err=1 for one cycle, IR/MDR unchanged.
REQ-030 mem_ack in IDLE SHALL be ignored.
REQ-031 MemRead/MemWrite/address inputs changing during REQ SHALL have no effect.
REQ-032 opcode and funct SHALL be combinational slices of ir.

Reset
REQ-033 reset=0 SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ir=0, mdr=0, counter=0, addr_err=0, timeout_err=0, including mid-access.
REQ-034 An ack arriving during or after an access aborted by reset SHALL be ignored.

Structure
REQ-035 Package micromips_pkg SHALL hold the state enum, TIMEOUT=16, and the opcode constants LW=6'b100011 and SW=6'b101011.
REQ-036 Single flat module; no sub-module.

Verification
REQ-037 Fetch: pc=0x100, MemRead=1, irwrite=1, instdata=0, ack after 3 wait cycles with rdata=0x8C220004 -> mem_addr=0x100, ir=0x8C220004, opcode=6'b100011, MDR unchanged.
REQ-038 Load: instdata=1, alu_addr=0x200, ack with rdata=0xDEADBEEF -> mdr=0xDEADBEEF, ir unchanged.
REQ-039 Store: MemWrite=1, alu_addr=0x204, wdata=0x12345678 -> mem_we=1 and mem_wdata=0x12345678 until ack.
REQ-040 Misaligned: alu_addr=0x202 -> no mem_req, addr_err=1 for one cycle.
REQ-041 Timeout: no ack -> mem_req drops after 16 REQ cycles, timeout_err=1 for one cycle; reset=0 mid-REQ -> mem_req=0 at once, ir=0.

Source files
------------

// File: rtl/micromips_pkg.sv
// micromips_pkg: shared state encoding, bus timeout limit and load/store opcodes
package micromips_pkg;
  typedef enum logic {IDLE, REQ} state_t;
  localparam int TIMEOUT = 16;
  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;
endpackage

// File: rtl/micromips_mem_ir_unit.sv
// micromips_mem_ir_unit: single-port memory bus master feeding IR (fetch) or MDR (load),
// with misaligned-address rejection and a no-ack timeout
module micromips_mem_ir_unit
  import micromips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        irwrite,
  input  logic        instdata,
  input  logic [31:0] pc,
  input  logic [31:0] alu_addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] mdr,
  output logic        mem_busy,
  output logic        addr_err,
  output logic        timeout_err
);
  state_t state, state_nx;
  logic [4:0] cnt;
  logic [31:0] addr;
  logic dest, start, misal, done, tmo;
  always_comb begin
    addr     = instdata ? alu_addr : pc;
    misal    = addr[1:0] != 2'b00;
    start    = (state == IDLE) && (MemRead || MemWrite);
    done     = (state == REQ) && mem_ack;
    tmo      = (state == REQ) && !mem_ack && (cnt == 5'(TIMEOUT - 1));
    state_nx = (start && !misal) ? REQ : (done || tmo) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      ir          <= '0;
      mdr         <= '0;
      cnt         <= '0;
      dest        <= 1'b0;
      addr_err    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      addr_err    <= start && misal;
      timeout_err <= tmo;
      if (start && !misal) begin
        mem_addr  <= addr;
        mem_wdata <= wdata;
        mem_we    <= MemWrite;
        dest      <= irwrite & ~instdata;
        cnt       <= '0;
      end
      if (state == REQ && !mem_ack) cnt <= cnt + 5'd1;
      if (done && !mem_we && dest) ir <= mem_rdata;
      if (done && !mem_we && !dest) mdr <= mem_rdata;
    end
  end
  assign mem_req  = state == REQ;
  assign mem_busy = state == REQ;
  assign opcode   = ir[31:26];
  assign funct    = ir[5:0];
endmodule
